// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 device-to-host receiver. Raw PS/2 clock/data pins are synchronised,
//   the clock is glitch filtered, 11-bit frames are validated (start, odd
//   parity, stop, inter-edge timeout), E0/F0 prefixes are folded into the
//   following scan code, and each decoded key event is queued in a
//   show-ahead FIFO.
//
// Parameters
//   CLK_FILTER     consecutive equal samples before filtered clock flips (>=2)
//   TIMEOUT_CYCLES clk cycles allowed between strobes inside a frame
//   FIFO_DEPTH     event FIFO depth, power of two, >=2
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_data    raw PS/2 data pin (asynchronous)
//   rd_en       pop request, ignored while empty
//   rd_data     head event {break, extended, code[7:0]}, valid while !empty
//   empty       FIFO empty
//   count       number of stored events (0..FIFO_DEPTH)
//   parity_err  1-cycle pulse on bad parity
//   frame_err   1-cycle pulse on bad start, bad stop or timeout
//   overflow    1-cycle pulse when an event is dropped on a full FIFO
module ps2_rx_fifo #(
  parameter int CLK_FILTER     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  input  logic                              rd_en,
  output logic [9:0]                        rd_data,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              parity_err,
  output logic                              frame_err,
  output logic                              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(CLK_FILTER + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Odd parity: the eight data bits and the parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // ---- Stage p0/p1: two-flop synchronisers (idle level of both pins is 1)
  logic clk_sync_p0, clk_sync_p1;
  logic dat_sync_p0, dat_sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
      dat_sync_p0 <= 1'b1;
      dat_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0 <= ps2_clk;
      clk_sync_p1 <= clk_sync_p0;
      dat_sync_p0 <= ps2_data;
      dat_sync_p1 <= dat_sync_p0;
    end
  end

  // ---- Clock filter: level flips after CLK_FILTER consecutive opposite samples
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip;
  logic          strobe;

  assign filt_flip = (clk_sync_p1 != filt_clk) && (filt_cnt == FW'(CLK_FILTER - 1));
  // The strobe is the cycle in which the filtered clock is about to fall.
  assign strobe    = filt_flip && filt_clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync_p1 != filt_clk) begin
      if (filt_flip) begin
        filt_clk <= clk_sync_p1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // ---- Frame FSM and prefix decoder; push request leaves as stage p0
  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          ext_flag;
  logic          brk_flag;
  logic [TW-1:0] tmo_cnt;
  logic          push_vld_p0;
  logic [9:0]    push_word_p0;
  logic          par_ok;
  logic          timeout;

  assign par_ok  = odd_parity_ok(shreg, par_bit);
  assign timeout = (state != IDLE) && !strobe && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_idx     <= '0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      tmo_cnt     <= '0;
      push_vld_p0 <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      push_vld_p0 <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      if (timeout) begin
        // Stalled frame: drop what was collected and any pending prefix.
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
        tmo_cnt   <= '0;
        state     <= IDLE;
      end else begin
        if (strobe || state == IDLE) tmo_cnt <= '0;
        else                         tmo_cnt <= tmo_cnt + 1'b1;
        if (strobe) begin
          case (state)
            IDLE: begin
              if (!dat_sync_p1) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                frame_err <= 1'b1;
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
              end
            end
            DATA: begin
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= PARITY;
            end
            PARITY: state <= STOP;
            STOP: begin
              state <= IDLE;
              if (par_ok && dat_sync_p1) begin
                case (shreg)
                  8'hE0:   ext_flag <= 1'b1;
                  8'hF0:   brk_flag <= 1'b1;
                  default: begin
                    push_vld_p0 <= 1'b1;
                    ext_flag    <= 1'b0;
                    brk_flag    <= 1'b0;
                  end
                endcase
              end else begin
                parity_err <= !par_ok;
                frame_err  <= !dat_sync_p1;
                ext_flag   <= 1'b0;
                brk_flag   <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // Data path registers carry no reset; they are qualified by the FSM.
  always_ff @(posedge clk) begin
    if (strobe && state == DATA)   shreg   <= {dat_sync_p1, shreg[7:1]};
    if (strobe && state == PARITY) par_bit <= dat_sync_p1;
    if (strobe && state == STOP)   push_word_p0 <= {brk_flag, ext_flag, shreg};
  end

  // ---- Stage p1: show-ahead FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_pop   = rd_en && !empty;
  // When full, a simultaneous pop frees the head slot, which is the one
  // being written (wr_ptr == rd_ptr), so both can proceed.
  assign do_push  = push_vld_p0 && (!full || do_pop);
  assign overflow = push_vld_p0 && full && !do_pop;
  assign rd_data  = empty ? 10'd0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with glitch filtering, full frame validation, make/break/extended-prefix decoding and a show-ahead output FIFO. It replaces the single-register keyboard front end: raw PS/2 clock/data pins go in, and decoded key events come out as queued 10-bit words. Downstream logic pops events at its own rate and can sit behind this block without ever missing a scan code.

## Interface
- CLK_FILTER, 4 — consecutive equal samples required before the filtered PS/2 clock changes level (≥2)
- TIMEOUT_CYCLES, 5000 — clk cycles allowed between PS/2 clock falling edges inside a frame
- FIFO_DEPTH, 8 — event FIFO depth, power of two, ≥2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- rd_en  in  1  pop request; ignored when empty
- rd_data  out  10  head event {break, extended, code[7:0]}; valid while empty=0
- empty  out  1  FIFO empty
- count  out  $clog2(FIFO_DEPTH+1)  words stored
- parity_err  out  1  one-cycle pulse, bad parity
- frame_err  out  1  one-cycle pulse, bad start, bad stop or timeout
- overflow  out  1  one-cycle pulse, event dropped because the FIFO was full

## Operation
- Both pins pass through a 2-FF synchroniser. The synchronised clock feeds a filter: the filtered level flips only after CLK_FILTER consecutive opposite samples. A falling edge of the filtered clock is one internal sample strobe; data is sampled from the synchronised ps2_data on that strobe.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with data=0 → DATA, bit index 0. Strobe with data=1 → frame_err pulse, stay in IDLE.
  - DATA: 8 strobes, LSB first, into the shift register → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: on the strobe, the byte is good if the XOR of the 8 data bits and the parity bit is 1 (odd parity) and stop=1. Otherwise, bad parity pulses parity_err and a bad stop pulses frame_err. If both are bad, both pulse. Return to IDLE.
- Timeout: outside IDLE, a counter clears on every strobe. Reaching TIMEOUT_CYCLES → frame_err pulse, partial frame discarded, return to IDLE.
- Any error also clears the pending ext/brk prefix flags.
- Decoder for each good byte:
  - 0xE0 → set ext.
  - 0xF0 → set brk.
  - Any other byte → push {brk, ext, byte}, then clear both flags.
  - Prefixes are never pushed.
- FIFO is show-ahead: rd_data shows the head word whenever empty=0. rd_en with empty=0 pops at the clock edge.
  - Push while full with no pop → word dropped, overflow pulse, contents unchanged.
  - Push and pop in the same cycle → both performed, count unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - count spans 0..FIFO_DEPTH.
- Reset, asynchronous and honoured mid-frame:
  - FSM → IDLE; flags, pointers and count → 0.
  - Filtered clock and synchronisers → 1.
  - Outputs: rd_data=0, empty=1, count=0, all error pulses and overflow=0.
  - A partial frame in flight is discarded.

## Timing
- Strobe occurs no later than CLK_FILTER+3 cycles after a clean ps2_clk pin fall.
- Push happens at the clock edge following the stop strobe. empty deasserts and count increments on the next cycle. Pin-to-visible latency is therefore ≤ CLK_FILTER+5 cycles.
- Error and overflow pulses are exactly 1 cycle wide and coincide with the cycle in which the push would have occurred.
- Pop: rd_data shows the next word and count decrements one cycle after rd_en is sampled high.
- Pulses on ps2_clk shorter than CLK_FILTER cycles never generate a strobe.
- Minimum supported PS/2 half-period: 2·(CLK_FILTER+3) cycles.

## Test plan
- Frame 0x1C (parity 0, stop 1) at 10 kHz → one word 0x01C, empty=0, count=1, no error pulses; rd_en pulse → empty=1, count=0.
- Bytes E0, F0, 75 (parities 0, 1, 0) → exactly one word 0x375; bytes F0, 1C → 0x21C; prefix flags are clear afterwards (a following 0x1C gives 0x01C).
- 0x1C frame with parity 1 → parity_err single pulse, no push. Next frame with stop=0 → frame_err pulse, no push. Start bit=1 → frame_err.
- Four bits sent, then the clock is held high for TIMEOUT_CYCLES → frame_err pulse. A following good 0x1C frame is received correctly.
- FIFO_DEPTH+1 frames with no reads → count=FIFO_DEPTH and one overflow pulse; draining returns the first FIFO_DEPTH codes in order. Push coincident with pop while full → count stays at FIFO_DEPTH, no overflow.
- 1-cycle glitches on ps2_clk → no strobe, no data corruption. reset asserted mid-frame → all outputs at reset values immediately; the next full frame is decoded correctly.
